// File: rtl/draw_pkg.sv
// draw_pkg: movement-FSM command codes, screen/colour constants, op enum and move helper.
// Defining SPRITE_DRAW_WRAP_EN makes moves wrap at the screen bounds instead of clamping.
package draw_pkg;
  localparam logic [3:0] HOLD    = 4'b0000;
  localparam logic [3:0] CLEAR   = 4'b0001;
  localparam logic [3:0] RIGHT   = 4'b0010;
  localparam logic [3:0] LEFT    = 4'b0011;
  localparam logic [3:0] PREHOLD = 4'b0100;
  localparam logic [3:0] DRAW    = 4'b0101;
  localparam logic [3:0] DOWN    = 4'b0110;
  localparam logic [3:0] UP      = 4'b0111;
  localparam logic [3:0] SHOT    = 4'b1000;
  localparam logic [3:0] ESCAPED = 4'b1001;
  localparam logic [3:0] IS_SHOT = 4'b1010;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] BG_COLOUR     = 3'b011;
  localparam logic [2:0] BIRD_COLOUR   = 3'b100;
  localparam logic [2:0] PLAYER_COLOUR = 3'b111;
  typedef enum logic {OP_CLEAR, OP_DRAW} op_t;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} eng_t;
  function automatic logic [7:0] move_coord(input logic [7:0] p, input logic inc,
                                            input logic [7:0] stp, input logic [7:0] maxv);
`ifdef SPRITE_DRAW_WRAP_EN
    return inc ? ((({1'b0, p} + {1'b0, stp}) > {1'b0, maxv}) ? 8'd0 : p + stp)
               : ((p < stp) ? maxv : p - stp);
`else
    return inc ? ((({1'b0, p} + {1'b0, stp}) > {1'b0, maxv}) ? maxv : p + stp)
               : ((p < stp) ? 8'd0 : p - stp);
`endif
  endfunction
endpackage

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter: row-major SIZE x SIZE scan; start presents pixel 0 in the same cycle.
module pixel_scan_counter #(
  parameter int SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  output logic [$clog2(SIZE)-1:0] row,
  output logic [$clog2(SIZE)-1:0] col,
  output logic                    last
);
  localparam int W = $clog2(SIZE);
  logic [2*W-1:0] cnt, idx;
  always_comb begin
    idx  = start ? '0 : cnt;
    row  = idx[2*W-1:W];
    col  = idx[W-1:0];
    last = &idx;
  end
  // wraps to zero after the last pixel, so an idle counter always sits at pixel 0
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (start || en) cnt <= idx + 1'b1;
endmodule

// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: bird/crosshair position keeper and sprite-box rasteriser for the VGA pixel port.
// Move behaviour at the screen bounds is selected by SPRITE_DRAW_WRAP_EN (wrap) or its absence (clamp).
module sprite_draw_engine import draw_pkg::*; #(
  parameter int SIZE      = 8,
  parameter int SCREEN_WD = SCREEN_W,
  parameter int SCREEN_HT = SCREEN_H,
  parameter int STEP      = 1,
  parameter int BIRD_X0   = 8,
  parameter int BIRD_Y0   = 8,
  parameter int PLAYER_X0 = 76,
  parameter int PLAYER_Y0 = 56
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] STATE,
  input  logic       PorB,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       doneDrawing,
  output logic [7:0] bird_x,
  output logic [6:0] bird_y,
  output logic [7:0] player_x,
  output logic [6:0] player_y
);
  localparam int W = $clog2(SIZE);
  localparam logic [W-1:0] MID = W'(SIZE / 2);
  localparam logic [7:0] XMAX = 8'(SCREEN_WD - SIZE);
  localparam logic [7:0] YMAX = 8'(SCREEN_HT - SIZE);
  eng_t st, st_n;
  op_t op_q;
  logic sel_q, start, busy, emit, draw, sel, vis, last;
  logic [3:0] state_prev;
  logic [W-1:0] row, col;
  logic [7:0] px, sx, nx;
  logic [6:0] py, sy, ny;
  logic [2:0] pix_colour;
  pixel_scan_counter #(.SIZE(SIZE)) u_scan (
    .clk(clk), .rst(reset), .start(start), .en(st == S_SCAN), .row(row), .col(col), .last(last)
  );
  always_comb begin
    busy        = st != S_IDLE;
    start       = !reset && !busy && STATE != state_prev && (STATE == CLEAR || STATE == DRAW);
    doneDrawing = !busy && !start;
    emit        = start || st == S_SCAN;
    st_n        = start ? S_SCAN : (st == S_SCAN && last) ? S_FLUSH : (st == S_FLUSH) ? S_IDLE : st;
    // the entry cycle already emits pixel 0, before op/select are latched
    draw        = start ? STATE == DRAW : op_q == OP_DRAW;
    sel         = start ? PorB : sel_q;
    px          = sel ? player_x : bird_x;
    py          = sel ? player_y : bird_y;
    vis         = !draw || !sel || col == MID || row == MID;
    pix_colour  = !draw ? BG_COLOUR : sel ? PLAYER_COLOUR : BIRD_COLOUR;
    sx          = PorB ? player_x : bird_x;
    sy          = PorB ? player_y : bird_y;
    nx          = (STATE == RIGHT || STATE == LEFT) ? move_coord(sx, STATE == RIGHT, 8'(STEP), XMAX) : sx;
    ny          = (STATE == DOWN || STATE == UP) ? 7'(move_coord({1'b0, sy}, STATE == DOWN, 8'(STEP), YMAX)) : sy;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st         <= S_IDLE;
      state_prev <= HOLD;
      op_q       <= OP_CLEAR;
      sel_q      <= 1'b0;
    end else begin
      st         <= st_n;
      state_prev <= STATE;
      if (start) begin
        op_q  <= (STATE == DRAW) ? OP_DRAW : OP_CLEAR;
        sel_q <= PorB;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= emit && vis;
      if (emit) begin
        x      <= px + 8'(col);
        y      <= py + 7'(row);
        colour <= pix_colour;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bird_x   <= 8'(BIRD_X0);
      bird_y   <= 7'(BIRD_Y0);
      player_x <= 8'(PLAYER_X0);
      player_y <= 7'(PLAYER_Y0);
    end else if (PorB) begin
      player_x <= nx;
      player_y <= ny;
    end else begin
      bird_x <= nx;
      bird_y <= ny;
    end
endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb_sprite_draw_engine: table-driven move checks, hand-written pass/reset sequences and random moves vs a position model.
module tb_sprite_draw_engine;
  localparam logic [3:0] C_HOLD = 4'd0, C_CLEAR = 4'd1, C_RIGHT = 4'd2, C_LEFT = 4'd3, C_DRAW = 4'd5;
  localparam logic [3:0] C_DOWN = 4'd6, C_UP = 4'd7, C_SHOT = 4'd8;
  localparam int XMAX = 152, YMAX = 112;
`ifdef SPRITE_DRAW_WRAP_EN
  localparam int NL = 9, ELX = 152, ND = 56, NU = 56;
`else
  localparam int NL = 10, ELX = 0, ND = 200, NU = 60;
`endif
  typedef struct {logic [3:0] cmd; logic sel; int n; int bx; int by; int px; int py;} vec_t;
  typedef struct {int x; int y; int c;} pix_t;
  logic clk = 1'b0, reset, PorB, plot, doneDrawing;
  logic [3:0] STATE;
  logic [7:0] x, bird_x, player_x;
  logic [6:0] y, bird_y, player_y;
  logic [2:0] colour;
  int checks = 0, fails = 0;
  int mbx, mby, mpx, mpy;
  vec_t tbl[8];
  always #5 clk = ~clk;
  sprite_draw_engine dut (
    .clk(clk), .reset(reset), .STATE(STATE), .PorB(PorB), .x(x), .y(y), .colour(colour),
    .plot(plot), .doneDrawing(doneDrawing), .bird_x(bird_x), .bird_y(bird_y),
    .player_x(player_x), .player_y(player_y)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic int mv(input int p, input int d, input int maxv);
`ifdef SPRITE_DRAW_WRAP_EN
    if (p + d > maxv) return 0;
    if (p + d < 0) return maxv;
`else
    if (p + d > maxv) return maxv;
    if (p + d < 0) return 0;
`endif
    return p + d;
  endfunction
  task automatic model_reset();
    mbx = 8; mby = 8; mpx = 76; mpy = 56;
  endtask
  task automatic do_reset();
    reset = 1'b1; STATE = C_HOLD; PorB = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask
  task automatic check_pos(input string tag);
    chk({tag, "_bird_x"}, bird_x, mbx);
    chk({tag, "_bird_y"}, bird_y, mby);
    chk({tag, "_player_x"}, player_x, mpx);
    chk({tag, "_player_y"}, player_y, mpy);
  endtask
  task automatic tick_cmd(input logic [3:0] cmd, input logic sel, input int n);
    STATE = cmd; PorB = sel;
    repeat (n) begin
      @(posedge clk);
      if (cmd == C_RIGHT) begin if (sel) mpx = mv(mpx, 1, XMAX); else mbx = mv(mbx, 1, XMAX); end
      if (cmd == C_LEFT) begin if (sel) mpx = mv(mpx, -1, XMAX); else mbx = mv(mbx, -1, XMAX); end
      if (cmd == C_DOWN) begin if (sel) mpy = mv(mpy, 1, YMAX); else mby = mv(mby, 1, YMAX); end
      if (cmd == C_UP) begin if (sel) mpy = mv(mpy, -1, YMAX); else mby = mv(mby, -1, YMAX); end
    end
    #1 STATE = C_HOLD;
  endtask
  task automatic run_pass(input logic [3:0] cmd, input logic sel);
    pix_t q[$];
    pix_t p;
    int bx, by, n, nexp;
    bx = sel ? mpx : mbx;
    by = sel ? mpy : mby;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (cmd == C_CLEAR) q.push_back('{x: bx + c, y: by + r, c: 3});
        else if (!sel) q.push_back('{x: bx + c, y: by + r, c: 4});
        else if (c == 4 || r == 4) q.push_back('{x: bx + c, y: by + r, c: 7});
    nexp = q.size();
    n = 0;
    STATE = cmd; PorB = sel;
    @(negedge clk);
    chk("entry_done", doneDrawing, 0);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("busy_done", doneDrawing, 0);
      if (plot) begin
        n++;
        if (q.size() == 0) chk("extra_plot", n, nexp);
        else begin
          p = q.pop_front();
          chk("pix_x", x, p.x);
          chk("pix_y", y, p.y);
          chk("pix_colour", colour, p.c);
        end
      end
    end
    @(negedge clk);
    chk("done_after_pass", doneDrawing, 1);
    chk("plot_after_pass", plot, 0);
    chk("plot_count", n, nexp);
    @(posedge clk) #1 STATE = C_HOLD;
    @(posedge clk) #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [3:0] codes[9];
    logic [3:0] cmd;
    logic sel;
    tbl[0] = '{C_LEFT, 1'b0, NL, ELX, 8, 76, 56};
    tbl[1] = '{C_DOWN, 1'b1, ND, 8, 8, 76, 112};
    tbl[2] = '{C_RIGHT, 1'b0, 144, 152, 8, 76, 56};
    tbl[3] = '{C_UP, 1'b1, NU, 8, 8, 76, 0};
    tbl[4] = '{C_RIGHT, 1'b1, 5, 8, 8, 81, 56};
    tbl[5] = '{C_UP, 1'b0, 3, 8, 5, 76, 56};
    tbl[6] = '{C_HOLD, 1'b0, 5, 8, 8, 76, 56};
    tbl[7] = '{C_SHOT, 1'b1, 4, 8, 8, 76, 56};
    codes = '{C_RIGHT, C_LEFT, C_DOWN, C_UP, C_SHOT, 4'd9, 4'd10, 4'd4, 4'd15};
    do_reset();
    @(negedge clk);
    chk("reset_done", doneDrawing, 1);
    chk("reset_plot", plot, 0);
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_colour", colour, 0);
    check_pos("reset");
    @(posedge clk) #1;
    run_pass(C_CLEAR, 1'b0);
    run_pass(C_DRAW, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_reset();
      tick_cmd(tbl[i].cmd, tbl[i].sel, tbl[i].n);
      chk($sformatf("tbl%0d_bird_x", i), bird_x, tbl[i].bx);
      chk($sformatf("tbl%0d_bird_y", i), bird_y, tbl[i].by);
      chk($sformatf("tbl%0d_player_x", i), player_x, tbl[i].px);
      chk($sformatf("tbl%0d_player_y", i), player_y, tbl[i].py);
    end
    do_reset();
    tick_cmd(C_RIGHT, 1'b0, 5);
    tick_cmd(C_UP, 1'b1, 3);
    STATE = C_DRAW; PorB = 1'b0;
    repeat (22) @(negedge clk);
    chk("mid_plot", plot, 1);
    chk("mid_x", x, 17);
    chk("mid_y", y, 10);
    #1 reset = 1'b1;
    #1;
    chk("abort_plot", plot, 0);
    chk("abort_done", doneDrawing, 1);
    model_reset();
    check_pos("abort");
    STATE = C_HOLD;
    @(posedge clk) #1 reset = 1'b0;
    @(posedge clk) #1;
    run_pass(C_DRAW, 1'b0);
    for (int it = 0; it < 30; it++) begin
      cmd = codes[$urandom_range(0, 8)];
      sel = 1'($urandom_range(0, 1));
      tick_cmd(cmd, sel, $urandom_range(1, 30));
      check_pos("rand");
      if (it % 5 == 4) run_pass($urandom_range(0, 1) ? C_DRAW : C_CLEAR, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sprite_draw_engine.md
# sprite_draw_engine

Datapath responder for the movement state machine: consumes its 4-bit `STATE` command code and `PorB` object select, keeps the bird and crosshair positions, and rasterises each sprite box to the VGA adapter pixel port. `doneDrawing` is the handshake back to the state machine. The block sits between the movement FSM and the VGA adapter; it also exports both positions for hit detection.

## Interface
- `SIZE`, 8: sprite box edge in pixels (power of two, ≤16)
- `SCREEN_W`, 160 / `SCREEN_H`, 120: drawable area
- `STEP`, 1: pixels moved per move command
- `BIRD_X0`/`BIRD_Y0`, 8/8; `PLAYER_X0`/`PLAYER_Y0`, 76/56: reset positions
- `BG_COLOUR` 3'b011, `BIRD_COLOUR` 3'b100, `PLAYER_COLOUR` 3'b111
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `STATE` in 4: command code from the movement FSM
- `PorB` in 1: object select; 0 = bird, 1 = player crosshair
- `x` out 8, `y` out 7, `colour` out 3, `plot` out 1: VGA pixel write port
- `doneDrawing` out 1: engine idle, no pass pending
- `bird_x`/`player_x` out 8, `bird_y`/`player_y` out 7: top-left positions

## Operation
- Command codes: HOLD 0000, CLEAR 0001, RIGHT 0010, LEFT 0011, PREHOLD 0100, DRAW 0101, DOWN 0110, UP 0111, SHOT 1000, ESCAPED 1001, IS_SHOT 1010. All other codes: no action.
- `state_prev` register samples `STATE` every cycle (reset value HOLD).
- `start` = (`STATE` != `state_prev`) and `STATE` ∈ {CLEAR, DRAW} and not busy. A start while busy is ignored.
- `doneDrawing` is combinational: !busy && !start. The FSM therefore never sees a stale done in its entry cycle.
- On start, the engine latches op (clear/draw) and `PorB`, sets busy, and zeroes the scan counter (row-major, col fastest).
- CLEAR pass: every one of SIZE² pixels is plotted with `BG_COLOUR` at the selected object's position.
- DRAW pass, bird: every pixel is plotted with `BIRD_COLOUR`.
- DRAW pass, player: a pixel is plotted (`PLAYER_COLOUR`) only where col==SIZE/2 or row==SIZE/2. Other pixels take a cycle with `plot`=0.
- Move: for each cycle `STATE` is RIGHT/LEFT/DOWN/UP, the object selected by the current `PorB` moves STEP in that direction. This takes one cycle per move, independent of busy.
- Bounds, default: x clamped to [0, SCREEN_W−SIZE], y clamped to [0, SCREEN_H−SIZE]. Moves past a bound leave that coordinate at the bound.
- `x`=pos_x+col and `y`=pos_y+row. Widths are exact, with no overflow given the clamping.

## Timing
- Reset values:
  - `plot` 0, `x`/`y`/`colour` 0, busy 0, so `doneDrawing`=1.
  - Positions at *_X0/*_Y0. `state_prev` HOLD.
- Start sampled in cycle c (`doneDrawing`=0 in c). Pixel i is presented registered in cycle c+1+i, i=0..SIZE²−1.
- busy clears at the end of cycle c+SIZE². `doneDrawing`=1 from cycle c+SIZE²+1 (SIZE=8: pixels c+1..c+64, done at c+65).
- Pass position is read live each pixel. A move during a pass shifts the remaining pixels; the FSM never does this.
- Reset mid-pass aborts immediately: `plot` 0, busy 0.

## Configuration
- `SPRITE_DRAW_WRAP_EN` defined: moves wrap modulo the bound instead of clamping.
  - x past SCREEN_W−SIZE wraps to 0; x below 0 wraps to SCREEN_W−SIZE.
  - y wraps the same way.
- Undefined: clamp as above.

## Structure
- `draw_pkg` holds:
  - State code localparams, shared with the movement FSM.
  - Screen dimensions and colour constants.
  - Op enum {OP_CLEAR, OP_DRAW}.
- One sub-module, `pixel_scan_counter`: SIZE×SIZE row/col counter with start, enable, last-pixel flag.
- Position registers and the move/clamp logic stay in the top module.

## Test plan
- Reset, `STATE`=HOLD: `doneDrawing`=1, `plot`=0, bird at (8,8), player at (76,56).
- `STATE` HOLD→CLEAR, `PorB`=0:
  - done low in the entry cycle.
  - 64 plots of colour 3'b011 covering x 8..15, y 8..15.
  - done high 65 cycles after entry.
- `STATE`=DRAW, `PorB`=1: exactly 15 plots of 3'b111, at col 4 or row 4 of box (76,56); 64-cycle pass.
- `PorB`=0, `STATE`=LEFT held 10 cycles from x=8: bird_x stops at 0.
  - With `SPRITE_DRAW_WRAP_EN`: bird_x=152 after the 9th cycle.
- `STATE`=DOWN held 200 cycles for player: player_y saturates at 112, player_x unchanged.
- Reset asserted at pixel 20 of a DRAW pass: `plot` drops immediately, `doneDrawing`=1, positions return to reset values.
